con_input_events: RTL and testbench

Downstream consumer of the controller subsystem's `con_state[15:0]` button vector.
- Samples the vector on a programmable tick and debounces each button independently.
- Maintains held, sticky-pressed and sticky-released masks.
- Serialises every debounced edge into a small event FIFO that the CPU bridge drains.
- Sits inside the IO subsystem, between the controller interface and the HPS register window.

---
 rtl/con_input_events.sv | 178 +++++++++++++++++
 tb/tb_con_input_events.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/con_input_events.sv
// -----------------------------------------------------------------------------
// con_input_events
//
// Debounces the controller button vector and turns every accepted edge into a
// 5-bit event in a small first-word-fall-through FIFO that the CPU bridge
// drains.
//
// Data flow:
//   - A free-running divider produces one sample tick every SAMPLE_DIV cycles.
//   - Each button is debounced on that tick. btn_held takes a new value only
//     after DEBOUNCE_SAMPLES consecutive ticks that disagree with it.
//   - Accepted edges set sticky masks (btn_pressed / btn_released) and pending
//     masks.
//   - A priority serialiser moves one pending edge per cycle into the FIFO.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   con_state     raw button vector, 1 = pressed
//   btn_held      debounced button state
//   btn_pressed   sticky, set on debounced 0->1
//   btn_released  sticky, set on debounced 1->0
//   clr_en        clear sticky bits selected by clr_mask (a set wins)
//   clr_mask      bit mask for clr_en
//   evt_valid     FIFO non-empty
//   evt_data      FIFO head {release_flag, button_index[3:0]}
//   evt_rd        pop head (ignored while empty)
//   evt_count     FIFO occupancy, 0..FIFO_DEPTH
//   evt_overflow  sticky, an event was dropped (wins over ovf_clr)
//   ovf_clr       clear evt_overflow
// -----------------------------------------------------------------------------
module con_input_events #(
   parameter int SAMPLE_DIV       = 50000,
   parameter int DEBOUNCE_SAMPLES = 4,
   parameter int FIFO_DEPTH       = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [15:0]                   con_state,
   output logic [15:0]                   btn_held,
   output logic [15:0]                   btn_pressed,
   output logic [15:0]                   btn_released,
   input  logic                          clr_en,
   input  logic [15:0]                   clr_mask,
   output logic                          evt_valid,
   output logic [4:0]                    evt_data,
   input  logic                          evt_rd,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          evt_overflow,
   input  logic                          ovf_clr
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE_SAMPLES) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Returns {found, release_flag, index}. Scanning from the top down lets the
   // lowest index overwrite, and within one index a press overwrites a release.
   function automatic logic [5:0] pick_event(input logic [15:0] pp,
                                             input logic [15:0] pr);
      logic [5:0] pick;
      pick = '0;
      for (int i = 15; i >= 0; i--) begin
         if (pr[i]) pick = {1'b1, 1'b1, 4'(i)};
         if (pp[i]) pick = {1'b1, 1'b0, 4'(i)};
      end
      return pick;
   endfunction

   logic [DIV_W-1:0]       div_cnt;
   logic                   tick;
   logic [15:0][DB_W-1:0]  db_cnt;
   logic [15:0][DB_W-1:0]  db_cnt_nxt;
   logic [15:0]            held_nxt;
   logic [15:0]            press_set;
   logic [15:0]            rel_set;
   logic [15:0]            pend_press;
   logic [15:0]            pend_rel;
   logic [5:0]             sel;
   logic                   push;
   logic [15:0]            sel_onehot;
   logic [15:0]            press_clr;
   logic [15:0]            rel_clr;
   logic [15:0]            sticky_clr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [4:0]             mem [FIFO_DEPTH];
   logic                   pop;
   logic                   full;
   logic                   wr;
   logic                   ovf_set;

   // ---- sample tick ----
   assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   // ---- per-bit debounce ----
   always_comb begin
      db_cnt_nxt = db_cnt;
      held_nxt   = btn_held;
      press_set  = '0;
      rel_set    = '0;
      if (tick) begin
         for (int i = 0; i < 16; i++) begin
            if (con_state[i] == btn_held[i]) begin
               db_cnt_nxt[i] = '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_SAMPLES - 1)) begin
               held_nxt[i]   = con_state[i];
               db_cnt_nxt[i] = '0;
               press_set[i]  = con_state[i];
               rel_set[i]    = ~con_state[i];
            end else begin
               db_cnt_nxt[i] = db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // ---- serialiser: one pending edge per cycle ----
   assign sel        = pick_event(pend_press, pend_rel);
   assign push       = sel[5];
   assign sel_onehot = 16'b1 << sel[3:0];
   assign press_clr  = (push && !sel[4]) ? sel_onehot : '0;
   assign rel_clr    = (push &&  sel[4]) ? sel_onehot : '0;
   assign sticky_clr = clr_en ? clr_mask : '0;

   // A dropped push still consumes its pending bit; only overflow records it.
   assign pop     = evt_rd & evt_valid;
   assign full    = (evt_count == CNT_W'(FIFO_DEPTH));
   assign wr      = push & (~full | pop);
   assign ovf_set = push & full & ~pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt       <= '0;
         btn_held     <= '0;
         btn_pressed  <= '0;
         btn_released <= '0;
         pend_press   <= '0;
         pend_rel     <= '0;
         evt_overflow <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         evt_count    <= '0;
      end else begin
         db_cnt       <= db_cnt_nxt;
         btn_held     <= held_nxt;
         btn_pressed  <= (btn_pressed  & ~sticky_clr) | press_set;
         btn_released <= (btn_released & ~sticky_clr) | rel_set;
         pend_press   <= (pend_press & ~press_clr) | press_set;
         pend_rel     <= (pend_rel   & ~rel_clr)   | rel_set;
         evt_overflow <= (evt_overflow & ~ovf_clr) | ovf_set;
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   evt_count <= evt_count + 1'b1;
            2'b01:   evt_count <= evt_count - 1'b1;
            default: evt_count <= evt_count;
         endcase
      end
   end

   // ---- FIFO storage ----
   // Storage holds data only; occupancy and pointers gate its visibility.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= sel[4:0];
   end

   assign evt_valid = (evt_count != '0);
   assign evt_data  = evt_valid ? mem[rd_ptr] : 5'd0;

endmodule

// File: tb/tb_con_input_events.sv
module tb_con_input_events;

   localparam int SAMPLE_DIV = 64;
   localparam int DEB        = 3;
   localparam int DEPTH      = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] con_state;
   logic [15:0] btn_held, btn_pressed, btn_released;
   logic        clr_en;
   logic [15:0] clr_mask;
   logic        evt_valid;
   logic [4:0]  evt_data;
   logic        evt_rd;
   logic [3:0]  evt_count;
   logic        evt_overflow;
   logic        ovf_clr;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   con_input_events #(
      .SAMPLE_DIV(SAMPLE_DIV), .DEBOUNCE_SAMPLES(DEB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .con_state(con_state),
      .btn_held(btn_held), .btn_pressed(btn_pressed), .btn_released(btn_released),
      .clr_en(clr_en), .clr_mask(clr_mask),
      .evt_valid(evt_valid), .evt_data(evt_data), .evt_rd(evt_rd),
      .evt_count(evt_count), .evt_overflow(evt_overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // Bench-side cycle count since reset release, used to stay on the tick grid.
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      step(n * SAMPLE_DIV);
   endtask

   // Advance to just after the next edge where the divider restarts.
   task automatic to_boundary();
      for (int k = 0; k < SAMPLE_DIV + 1; k++) begin
         step(1);
         if (cyc % SAMPLE_DIV == 0) return;
      end
      check("align", 0, 1);
   endtask

   task automatic pop(input string tag, input logic [4:0] exp);
      check({tag, "_valid"}, evt_valid, 1);
      check(tag, evt_data, exp);
      evt_rd = 1'b1;
      step(1);
      evt_rd = 1'b0;
   endtask

   task automatic clr_all();
      clr_en   = 1'b1;
      clr_mask = 16'hFFFF;
      ovf_clr  = 1'b1;
      step(1);
      clr_en   = 1'b0;
      clr_mask = 16'h0000;
      ovf_clr  = 1'b0;
   endtask

   // Reset is released #1 after an edge; that edge counts as divider cycle 0.
   task automatic do_reset(input logic [15:0] cs);
      step(1);
      rst_n     = 1'b0;
      con_state = cs;
      step(2);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; con_state = 16'hFFFF; clr_en = 0; clr_mask = 0;
      evt_rd = 0; ovf_clr = 0;
      step(3);
      // Test 1: reset with all buttons held
      check("rst_held", btn_held, 0);
      check("rst_pressed", btn_pressed, 0);
      check("rst_released", btn_released, 0);
      check("rst_valid", evt_valid, 0);
      check("rst_data", evt_data, 0);
      check("rst_count", evt_count, 0);
      check("rst_ovf", evt_overflow, 0);
      rst_n = 1'b1;
      step(191);
      check("t1_held_early", btn_held, 16'h0000);
      step(1);
      check("t1_held_192", btn_held, 16'hFFFF);
      check("t1_pressed", btn_pressed, 16'hFFFF);
      step(20);
      check("t1_count_full", evt_count, 8);
      check("t1_ovf", evt_overflow, 1);
      pop("t1_pop0", 5'h00);
      pop("t1_pop1", 5'h01);
      // Reset mid-operation discards the queue
      do_reset(16'h0000);
      check("t1_rst_count", evt_count, 0);
      check("t1_rst_valid", evt_valid, 0);
      check("t1_rst_ovf", evt_overflow, 0);
      check("t1_rst_held", btn_held, 0);

      // Test 2: single press from idle
      to_boundary();
      con_state = 16'h0001;
      ticks(2);
      check("t2_held_2ticks", btn_held, 0);
      ticks(1);
      check("t2_held", btn_held, 16'h0001);
      check("t2_pressed", btn_pressed, 16'h0001);
      step(1);
      check("t2_count", evt_count, 1);
      pop("t2_pop", 5'h00);
      check("t2_empty", evt_valid, 0);

      // Test 3: short glitch on bit 5 is rejected
      to_boundary();
      con_state = 16'h0021;
      ticks(2);
      con_state = 16'h0001;
      ticks(3);
      check("t3_held", btn_held, 16'h0001);
      check("t3_pressed", btn_pressed, 16'h0001);
      check("t3_count", evt_count, 0);

      // Return to idle and clear sticky state
      clr_all();
      check("clr_pressed", btn_pressed, 0);
      to_boundary();
      con_state = 16'h0000;
      ticks(3);
      step(1);
      check("idle_released", btn_released, 16'h0001);
      pop("idle_pop", 5'h10);
      clr_all();

      // Test 4: ordering of presses and releases
      to_boundary();
      con_state = 16'h8003;
      ticks(3);
      check("t4_held", btn_held, 16'h8003);
      check("t4_pressed", btn_pressed, 16'h8003);
      step(3);
      check("t4_count", evt_count, 3);
      pop("t4_p0", 5'h00);
      pop("t4_p1", 5'h01);
      pop("t4_p15", 5'h0F);
      to_boundary();
      con_state = 16'h0000;
      ticks(3);
      step(3);
      check("t4_released", btn_released, 16'h8003);
      pop("t4_r0", 5'h10);
      pop("t4_r1", 5'h11);
      pop("t4_r15", 5'h1F);
      check("t4_empty", evt_valid, 0);
      clr_all();

      // Test 5: overflow with no reads
      to_boundary();
      con_state = 16'hFFFF;
      ticks(3);
      step(20);
      check("t5_count", evt_count, 8);
      check("t5_ovf", evt_overflow, 1);
      for (int i = 0; i < 8; i++) pop("t5_pop", 5'(i));
      check("t5_empty", evt_valid, 0);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      check("t5_ovf_clr", evt_overflow, 0);
      to_boundary();
      con_state = 16'h0000;
      ticks(3);
      step(20);
      for (int i = 0; i < 8; i++) pop("t5_rpop", 5'(16 + i));
      clr_all();
      check("t5_idle_ovf", evt_overflow, 0);

      // Test 6: set beats clear on the same cycle
      to_boundary();
      con_state = 16'h0004;
      step(3 * SAMPLE_DIV - 1);
      clr_en = 1'b1;
      clr_mask = 16'h0004;
      step(1);
      clr_en = 1'b0;
      clr_mask = 16'h0000;
      check("t6_set_wins", btn_pressed, 16'h0004);
      clr_en = 1'b1;
      clr_mask = 16'h0004;
      step(1);
      clr_en = 1'b0;
      clr_mask = 16'h0000;
      check("t6_clear", btn_pressed, 16'h0000);
      pop("t6_pop", 5'h02);

      // Push and pop together while full
      to_boundary();
      con_state = 16'hFFFF;
      ticks(3);
      step(8);
      check("t6_full", evt_count, 8);
      check("t6_no_ovf", evt_overflow, 0);
      pop("t6_head", 5'h00);
      check("t6_count_same", evt_count, 8);
      check("t6_ovf_same", evt_overflow, 0);
      check("t6_next_head", evt_data, 5'h01);
      step(1);
      check("t6_ovf_later", evt_overflow, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
